lms_ctr_onchip_ram_dp: RTL
==========================

// Module: lms_ctr_onchip_ram_dp
// PURPOSE
//  Parametrised true-dual-port on-chip RAM with two Avalon-MM slave ports, s1 and s2, in one clock domain.
//  Successor to the fixed 8192x32 single-port Nios II program/data RAM.
//  Adds: generic width/depth, selectable read latency, readdatavalid/waitrequest handshake,
//  a second port for DMA or debug access, write-collision arbitration and optional clear-after-reset.
//  Sits on the lms_ctr Qsys fabric: CPU data master on s1, peripheral/DMA master on s2.
// PARAMETERS
//  DATA_W        32   word width in bits; must be a multiple of 8
//  ADDR_W        13   word address width; depth = 2**ADDR_W
//  READ_LATENCY  1    cycles from accepted read to readdatavalid; legal values 1 or 2 (2 = output register)
//  INIT_CLEAR    0    1 = after reset, write zero to every word before accepting any access
// PORTS
//  clk              in   1          single clock for both ports
//  reset            in   1          asynchronous, active-high
//  clken            in   1          global clock enable; 0 stalls both ports and their read pipelines
//  reset_req        in   1          1 behaves as clken=0 (protects RAM during reset sequencing)
//  freeze           in   1          1 blocks all writes; reads still serviced
//  s1_address       in   ADDR_W     port 1 word address
//  s1_chipselect    in   1          port 1 select
//  s1_read          in   1          port 1 read request
//  s1_write         in   1          port 1 write request
//  s1_byteenable    in   DATA_W/8   port 1 byte lanes
//  s1_writedata     in   DATA_W     port 1 write data
//  s1_readdata      out  DATA_W     port 1 read data
//  s1_readdatavalid out  1          port 1 read data valid, 1-cycle pulse
//  s1_waitrequest   out  1          port 1 stall
//  s2_*             (same set)      port 2, identical widths and meaning
// BEHAVIOUR
//  Reset values
//  - sN_readdata = 0, sN_readdatavalid = 0.
//  - sN_waitrequest = 1 if INIT_CLEAR=1, else 0.
//  - RAM contents are not reset (except by the clear FSM).
//  Enable
//  - en = clken & ~reset_req.
//  - When en=0: waitrequest=1 on both ports, no access accepted, and the read pipeline holds.
//    valid is not re-asserted while held.
//  Accept
//  - A request is accepted on a cycle with chipselect & (read|write) & ~waitrequest.
//  - read and write asserted together in the same cycle on one port: treated as a write only.
//    No readdatavalid is produced.
//  Read
//  - readdata/readdatavalid appear exactly READ_LATENCY enabled cycles after acceptance.
//  - Pipelined: one read per port per cycle, in order. No back-pressure on read data.
//  - readdata holds its last value while readdatavalid=0.
//  Write
//  - Written bytes are those with byteenable=1. All-zero byteenable leaves the word unchanged.
//  - freeze=1: the write is accepted (no stall) but discarded.
//  Read-during-write
//  - Same port: old data.
//  - Port A reads the address port B writes in the same cycle: old data.
//  Collision
//  - Both ports write the same address in the same cycle: per byte lane, s1 wins where both
//    lanes are enabled, and s2 lands where only s2 is enabled.
//  - No stall is inserted.
//  Clear FSM (INIT_CLEAR=1)
//  - States IDLE, CLEAR, READY. Reset deassert -> CLEAR.
//  - CLEAR writes 0 to address ctr = 0 .. 2**ADDR_W-1, one word per enabled cycle.
//    ctr is ADDR_W+1 bits wide so the terminal count is detected without wrap.
//  - At last address -> READY; waitrequest drops on the cycle after the final write.
//  - freeze does not block the clear. reset mid-clear restarts from address 0.
//  - INIT_CLEAR=0: FSM held in READY.
//  Address wrap
//  - Addresses are exactly ADDR_W bits; there is no out-of-range case.
// TESTING
//  1 Defaults, s1 writes 0xDEADBEEF @0x0005 be=0xF; s1 reads @0x0005 next cycle.
//    -> readdatavalid 1 cycle after accept; readdata=0xDEADBEEF.
//  2 be=0x3 write 0x11112222 over 0xDEADBEEF; read on s2 with READ_LATENCY=2.
//    -> 0xDEAD2222, valid 2 cycles after accept.
//  3 Same cycle: s1 writes 0xAAAAAAAA be=0x5 and s2 writes 0xBBBBBBBB be=0xF, both @0x0100.
//    -> word reads back 0xBBAABBAA.
//  4 freeze=1 write 0x12345678 @0x0010 (old value 0); clken=0 for 3 cycles mid read burst.
//    -> reads 0; waitrequest=1 while stalled; no lost or duplicated readdatavalid.
//  5 INIT_CLEAR=1, ADDR_W=4, RAM preloaded with 0xFF.
//    -> waitrequest=1 for 16 cycles after reset; all words read 0.
//    Assert reset at clear address 7 -> clear restarts at address 0.
//  6 Back-to-back reads @0,1,2,3 on both ports, READ_LATENCY=1.
//    -> 4 consecutive valid pulses per port, in order, data matching earlier writes.

Source files
------------

// File: rtl/lms_ctr_onchip_ram_dp.sv
// lms_ctr_onchip_ram_dp
// True-dual-port on-chip RAM with two Avalon-MM slave ports (s1, s2) sharing one
// clock. Byte-lane writes, 1- or 2-cycle pipelined reads with readdatavalid,
// waitrequest driven by the clock enable and by an optional clear-after-reset FSM.
// On a same-address write collision s1 owns every lane it enables and s2 fills the rest.

module lms_ctr_onchip_ram_dp #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 13,
    parameter int READ_LATENCY = 1,
    parameter int INIT_CLEAR   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clken,
    input  logic                reset_req,
    input  logic                freeze,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic                s1_chipselect,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic                s1_waitrequest,
    input  logic [ADDR_W-1:0]   s2_address,
    input  logic                s2_chipselect,
    input  logic                s2_read,
    input  logic                s2_write,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    input  logic [DATA_W-1:0]   s2_writedata,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_readdatavalid,
    output logic                s2_waitrequest
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    // ctr carries one spare bit so the last address is compared without wrapping
    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] CTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam state_t RESET_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W:0]   ctr;
    logic [ADDR_W:0]   ctr_next;
    logic              clear_we;

    logic              en;
    logic              stall;
    logic [1:0]        rd_acc;
    logic [1:0]        we;

    logic [DATA_W-1:0]         mem [DEPTH];
    logic [1:0][DATA_W-1:0]    rd_word;
    logic [1:0]                stage_valid;
    logic [1:0][DATA_W-1:0]    stage_data;
    logic [1:0]                out_valid;
    logic [1:0][DATA_W-1:0]    out_data;

    // reset_req is folded into the enable so the RAM is untouched during reset sequencing
    assign en    = clken & ~reset_req;
    assign stall = ~en | (state != ST_READY);

    assign s1_waitrequest = stall;
    assign s2_waitrequest = stall;

    // read+write together is a write, so only a pure read starts the read pipeline
    assign rd_acc[0] = s1_chipselect & s1_read & ~s1_write & ~stall;
    assign rd_acc[1] = s2_chipselect & s2_read & ~s2_write & ~stall;

    // frozen writes are still accepted (no stall) but never reach the array
    assign we[0] = s1_chipselect & s1_write & ~stall & ~freeze;
    assign we[1] = s2_chipselect & s2_write & ~stall & ~freeze;

    // clear FSM state and address counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RESET_STATE;
            ctr   <= '0;
        end else begin
            state <= state_next;
            ctr   <= ctr_next;
        end
    end

    // clear FSM next state: one zero word per enabled cycle, freeze does not apply
    always_comb begin
        state_next = state;
        ctr_next   = ctr;
        clear_we   = 1'b0;
        case (state)
            ST_IDLE: begin
                state_next = RESET_STATE;
                ctr_next   = '0;
            end
            ST_CLEAR: begin
                if (en) begin
                    clear_we = 1'b1;
                    if (ctr == LAST_ADDR) begin
                        state_next = ST_READY;
                        ctr_next   = '0;
                    end else begin
                        ctr_next = ctr + CTR_ONE;
                    end
                end else begin
                    clear_we = 1'b0;
                end
            end
            ST_READY: begin
                state_next = ST_READY;
            end
            default: begin
                state_next = RESET_STATE;
                ctr_next   = '0;
            end
        endcase
    end

    // RAM array write; s2 lanes go first so an s1 lane on the same word overrides them
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[ctr[ADDR_W-1:0]] <= '0;
        end else begin
            for (int i = 0; i < BE_W; i++) begin
                if (we[1] && s2_byteenable[i]) begin
                    mem[s2_address][i*8 +: 8] <= s2_writedata[i*8 +: 8];
                end
                if (we[0] && s1_byteenable[i]) begin
                    mem[s1_address][i*8 +: 8] <= s1_writedata[i*8 +: 8];
                end
            end
        end
    end

    // array read is sampled before this cycle's writes land, giving old data on overlap
    assign rd_word[0] = mem[s1_address];
    assign rd_word[1] = mem[s2_address];

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [1:0]             p1_valid;
            logic [1:0][DATA_W-1:0] p1_data;

            // first read stage; holds its contents whenever the enable is low
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    p1_valid <= '0;
                    p1_data  <= '0;
                end else if (en) begin
                    p1_valid <= rd_acc;
                    for (int p = 0; p < 2; p++) begin
                        if (rd_acc[p]) begin
                            p1_data[p] <= rd_word[p];
                        end
                    end
                end
            end

            assign stage_valid = p1_valid;
            assign stage_data  = p1_data;
        end else begin : g_lat1
            assign stage_valid = rd_acc;
            assign stage_data  = rd_word;
        end
    endgenerate

    // output stage: valid pulses only on enabled edges so a held entry is never repeated
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                out_valid[p] <= en & stage_valid[p];
                if (en && stage_valid[p]) begin
                    out_data[p] <= stage_data[p];
                end
            end
        end
    end

    assign s1_readdata      = out_data[0];
    assign s1_readdatavalid = out_valid[0];
    assign s2_readdata      = out_data[1];
    assign s2_readdatavalid = out_valid[1];

endmodule
